// File: rtl/freq_counter_wb_master.sv
// Wishbone classic initiator that runs one frequency measurement on the
// frequency counter peripheral. The sequence is: pulse the counter reset,
// arm it, poll the done flag, read coarse and fine counts, then clear control.
//
// Ports:
//   clk_i, ext_rst_i        clock, asynchronous active-low reset
//   start_i                 measurement request (only honoured in IDLE)
//   addr_o/dat_o/we_o/sel_o Wishbone request lines
//   cyc_o/stb_o             Wishbone cycle / strobe
//   dat_i/ack_i/err_i/rty_i Wishbone response lines
//   busy_o, done_o          sequence running / one-cycle end pulse
//   coarse_o, fine_o        counts from the last successful measurement
//   error_o                 0 ok, 1 bus error or retries exhausted,
//                           2 ack timeout, 3 poll timeout
//
// state       | meaning
// S_IDLE      | waiting for start_i
// S_WR_RST    | write 0x01 to control (counter reset)
// S_WR_ARM    | write 0x80 to control (start measurement)
// S_RD_POLL   | read control, test done flag (bit 6)
// S_POLL_WAIT | idle gap between polls
// S_RD_COARSE | read coarse count
// S_RD_FINE   | read fine count
// S_WR_CLR    | write 0x00 to control
// S_FINISH    | publish results, pulse done_o
module freq_counter_wb_master #(
  parameter logic [31:0] CTRL_ADDR   = 32'h8,
  parameter logic [31:0] COARSE_ADDR = 32'h9,
  parameter logic [31:0] FINE_ADDR   = 32'hA,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned POLL_LIMIT  = 1024
) (
  input  logic        clk_i,
  input  logic        ext_rst_i,
  input  logic        start_i,
  output logic [31:0] addr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] coarse_o,
  output logic [31:0] fine_o,
  output logic [1:0]  error_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_RST, S_WR_ARM, S_RD_POLL, S_POLL_WAIT,
    S_RD_COARSE, S_RD_FINE, S_WR_CLR, S_FINISH
  } state_t;

  localparam logic [15:0] TMO_LOAD = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIM = 16'(POLL_LIMIT);
  localparam logic [7:0]  RTY_LIM  = 8'(RETRY_MAX);
  localparam logic [1:0]  E_BUS    = 2'd1;
  localparam logic [1:0]  E_TMO    = 2'd2;
  localparam logic [1:0]  E_POLL   = 2'd3;

  state_t      state_q;
  logic        cyc_q, stb_q, we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, dat_q;
  logic        busy_q, done_q;
  logic [1:0]  error_q, err_code_q;
  logic [31:0] coarse_q, fine_q, coarse_hold_q, fine_hold_q;
  logic [15:0] tmo_q, gap_q, poll_q;
  logic [7:0]  rty_q;

  state_t      issue_st;
  logic [31:0] tx_addr, tx_wdat;
  logic        tx_we;
  logic        bus_end;
  logic [15:0] poll_inc;

  // The last POLL_WAIT cycle launches the poll read directly, so the decode
  // looks at the state the transaction belongs to.
  always_comb begin
    issue_st = (state_q == S_POLL_WAIT) ? S_RD_POLL : state_q;
    tx_addr  = CTRL_ADDR;
    tx_we    = 1'b0;
    tx_wdat  = '0;
    case (issue_st)
      S_WR_RST:    begin tx_we = 1'b1; tx_wdat = 32'h01; end
      S_WR_ARM:    begin tx_we = 1'b1; tx_wdat = 32'h80; end
      S_RD_COARSE: tx_addr = COARSE_ADDR;
      S_RD_FINE:   tx_addr = FINE_ADDR;
      S_WR_CLR:    tx_we = 1'b1;
      default:     ;
    endcase
  end

  assign bus_end  = cyc_q && (err_i || rty_i || ack_i || (tmo_q == '0));
  assign poll_inc = poll_q + 16'd1;

  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state_q       <= S_IDLE;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      addr_q        <= '0;
      dat_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= '0;
      err_code_q    <= '0;
      coarse_q      <= '0;
      fine_q        <= '0;
      coarse_hold_q <= '0;
      fine_hold_q   <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
      poll_q        <= '0;
      rty_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_WR_RST;
            busy_q     <= 1'b1;
            error_q    <= '0;
            err_code_q <= '0;
            poll_q     <= '0;
            rty_q      <= '0;
          end
        end
        S_POLL_WAIT: begin
          if (gap_q == '0) begin
            state_q <= S_RD_POLL;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            sel_q   <= 4'hF;
            addr_q  <= tx_addr;
            we_q    <= tx_we;
            dat_q   <= tx_wdat;
            tmo_q   <= TMO_LOAD;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          error_q <= err_code_q;
          if (err_code_q == '0) begin
            coarse_q <= coarse_hold_q;
            fine_q   <= fine_hold_q;
          end
          state_q <= S_IDLE;
        end
        default: begin
          if (!cyc_q) begin
            // Entry into a bus state (or after a retry) spends one idle
            // cycle here before the strobe goes out.
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            sel_q  <= 4'hF;
            addr_q <= tx_addr;
            we_q   <= tx_we;
            dat_q  <= tx_wdat;
            tmo_q  <= TMO_LOAD;
          end else begin
            if (bus_end) begin
              cyc_q  <= 1'b0;
              stb_q  <= 1'b0;
              sel_q  <= '0;
              we_q   <= 1'b0;
              addr_q <= '0;
              dat_q  <= '0;
            end
            if (err_i) begin
              err_code_q <= E_BUS;
              state_q    <= S_FINISH;
            end else if (rty_i) begin
              if (rty_q == RTY_LIM) begin
                err_code_q <= E_BUS;
                state_q    <= S_FINISH;
              end else begin
                rty_q <= rty_q + 8'd1;
              end
            end else if (ack_i) begin
              rty_q <= '0;
              case (state_q)
                S_WR_RST: state_q <= S_WR_ARM;
                S_WR_ARM: state_q <= S_RD_POLL;
                S_RD_POLL: begin
                  if (dat_i[6]) begin
                    state_q <= S_RD_COARSE;
                  end else begin
                    poll_q <= poll_inc;
                    if (poll_inc == POLL_LIM) begin
                      err_code_q <= E_POLL;
                      state_q    <= S_FINISH;
                    end else begin
                      gap_q   <= GAP_LOAD;
                      state_q <= S_POLL_WAIT;
                    end
                  end
                end
                S_RD_COARSE: begin
                  coarse_hold_q <= dat_i;
                  state_q       <= S_RD_FINE;
                end
                S_RD_FINE: begin
                  fine_hold_q <= dat_i;
                  state_q     <= S_WR_CLR;
                end
                default: state_q <= S_FINISH;
              endcase
            end else if (tmo_q == '0) begin
              err_code_q <= E_TMO;
              state_q    <= S_FINISH;
            end else begin
              tmo_q <= tmo_q - 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign addr_o   = addr_q;
  assign dat_o    = dat_q;
  assign we_o     = we_q;
  assign sel_o    = sel_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = stb_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign coarse_o = coarse_q;
  assign fine_o   = fine_q;
  assign error_o  = error_q;

endmodule

// File: tb/tb_freq_counter_wb_master.sv
// Bench for freq_counter_wb_master: a scripted Wishbone slave acks on the
// second strobe edge, with per-run knobs for done-flag timing, err_i on the
// coarse read, never acking the arm write, and rty_i on the reset write.
module tb_freq_counter_wb_master;

  logic        clk = 1'b0;
  logic        ext_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] addr_o, dat_o;
  logic [31:0] dat_i = '0;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] coarse_o, fine_o;
  logic [1:0]  error_o;

  freq_counter_wb_master #(.POLL_LIMIT(4)) dut (
    .clk_i(clk), .ext_rst_i(ext_rst_i), .start_i(start_i),
    .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
    .busy_o(busy_o), .done_o(done_o), .coarse_o(coarse_o), .fine_o(fine_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    int          start;
    int          len;
    int          fall;
    logic [2:0]  term;  // {err, rty, ack} seen on the last strobe cycle
  } tx_t;

  typedef struct {
    int          done_on;
    bit          err_c;
    bit          noack;
    int          rty;
    logic [31:0] c;
    logic [31:0] f;
    logic [1:0]  x_err;
    logic [31:0] x_c;
    logic [31:0] x_f;
    int          x_ntx;
  } vec_t;

  tx_t         log_q[$];
  tx_t         cur;
  int          ncyc = 0, done_cnt = 0, sel_viol = 0, stab_viol = 0;
  int          stb_cnt = 0, rty_left = 0, poll_reads = 0;
  int          cfg_done_on = 0;
  bit          cfg_err_c = 1'b0, cfg_noack = 1'b0;
  logic [31:0] cfg_c = '0, cfg_f = '0;
  logic        prev_stb = 1'b0;

  int          n_err = 0, n_chk = 0;
  logic [1:0]  res_err;
  logic [31:0] res_c, res_f;
  logic        res_busy;
  bit          got_done;

  // Bus monitor followed by the slave model, both on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (cyc_o ? (sel_o != 4'hF) : (sel_o != 4'h0)) sel_viol++;
    if (done_o) done_cnt++;
    if (stb_o && !prev_stb) begin
      cur.we = we_o; cur.addr = addr_o; cur.dat = dat_o;
      cur.start = ncyc; cur.len = 0; cur.fall = 0; cur.term = '0;
    end else if (stb_o && (we_o !== cur.we || addr_o !== cur.addr || dat_o !== cur.dat)) begin
      stab_viol++;
    end
    if (!stb_o && prev_stb) begin
      cur.len = ncyc - cur.start;
      cur.fall = ncyc;
      cur.term = {err_i, rty_i, ack_i};
      log_q.push_back(cur);
    end
    prev_stb = stb_o;

    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
    if (cyc_o && stb_o) begin
      stb_cnt++;
      if (stb_cnt == 2) begin
        if (we_o && addr_o == 32'h8 && dat_o == 32'h1 && rty_left > 0) begin
          rty_i = 1'b1;
          rty_left--;
        end else if (we_o && addr_o == 32'h8 && dat_o == 32'h80 && cfg_noack) begin
          ack_i = 1'b0;
        end else if (!we_o && addr_o == 32'h9 && cfg_err_c) begin
          err_i = 1'b1;
        end else begin
          ack_i = 1'b1;
          if (!we_o) begin
            case (addr_o)
              32'h8: begin
                poll_reads++;
                dat_i = (cfg_done_on != 0 && poll_reads >= cfg_done_on) ? 32'h40 : 32'hFFFF_FFBF;
              end
              32'h9:   dat_i = cfg_c;
              32'hA:   dat_i = cfg_f;
              default: dat_i = 32'hDEAD_BEEF;
            endcase
          end
        end
      end
    end else begin
      stb_cnt = 0;
    end
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {cyc_o, stb_o, we_o, sel_o, busy_o, done_o, error_o}, 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_dat"}, dat_o, 0);
    check({tag, "_coarse"}, coarse_o, 0);
    check({tag, "_fine"}, fine_o, 0);
  endtask

  task automatic run_meas(input int done_on, input bit err_c, input bit noack,
                          input int rty, input logic [31:0] c, input logic [31:0] f);
    cfg_done_on = done_on; cfg_err_c = err_c; cfg_noack = noack;
    rty_left = rty; cfg_c = c; cfg_f = f; poll_reads = 0;
    log_q.delete();
    done_cnt = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("busy_on_start", busy_o, 1);
    check("error_clr_on_start", error_o, 0);
    got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      if (done_o) begin
        got_done = 1'b1;
        res_err = error_o; res_c = coarse_o; res_f = fine_o; res_busy = busy_o;
      end
    end
    check("done_seen", got_done, 1);
    check("busy_low_at_done", res_busy, 0);
    repeat (12) @(negedge clk);
    check("single_done_pulse", done_cnt, 1);
    check("busy_idle_after", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic        we_e[8];
    logic [31:0] ad_e[8];
    logic [31:0] dt_e[8];
    int          gap_e[8];
    bit          found;

    vecs[0] = '{3, 1'b0, 1'b0, 0, 32'd1000, 32'd1003, 2'd0, 32'd1000, 32'd1003, 8};
    vecs[1] = '{1, 1'b1, 1'b0, 0, 32'd5,    32'd6,    2'd1, 32'd1000, 32'd1003, 4};
    vecs[2] = '{1, 1'b0, 1'b1, 0, 32'd5,    32'd6,    2'd2, 32'd1000, 32'd1003, 2};
    vecs[3] = '{1, 1'b0, 1'b0, 2, 32'd7,    32'd9,    2'd0, 32'd7,    32'd9,    8};
    vecs[4] = '{1, 1'b0, 1'b0, 4, 32'd11,   32'd12,   2'd1, 32'd7,    32'd9,    4};
    vecs[5] = '{0, 1'b0, 1'b0, 0, 32'd11,   32'd12,   2'd3, 32'd7,    32'd9,    6};
    vecs[6] = '{2, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'd0, 2'd0, 32'hFFFF_FFFF, 32'd0, 7};

    we_e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ad_e  = '{32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'h9, 32'hA, 32'h8};
    dt_e  = '{32'h1, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    gap_e = '{0, 1, 1, 8, 8, 1, 1, 1};

    #1 ext_rst_i = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    ext_rst_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_meas(vecs[i].done_on, vecs[i].err_c, vecs[i].noack, vecs[i].rty, vecs[i].c, vecs[i].f);
      check($sformatf("v%0d_error", i), res_err, vecs[i].x_err);
      check($sformatf("v%0d_coarse", i), res_c, vecs[i].x_c);
      check($sformatf("v%0d_fine", i), res_f, vecs[i].x_f);
      check($sformatf("v%0d_ntx", i), log_q.size(), vecs[i].x_ntx);
    end

    // Nominal bus trace: order, data, 2-cycle strobes, idle gaps.
    run_meas(3, 1'b0, 1'b0, 0, 32'd1000, 32'd1003);
    check("nom_ntx", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check($sformatf("nom_tx%0d_we", i), log_q[i].we, we_e[i]);
      check($sformatf("nom_tx%0d_addr", i), log_q[i].addr, ad_e[i]);
      check($sformatf("nom_tx%0d_dat", i), log_q[i].dat, dt_e[i]);
      check($sformatf("nom_tx%0d_len", i), log_q[i].len, 2);
      if (i > 0) check($sformatf("nom_tx%0d_gap", i), log_q[i].start - log_q[i-1].fall, gap_e[i]);
    end
    check("nom_error", res_err, 0);
    check("nom_coarse", res_c, 32'd1000);
    check("nom_fine", res_f, 32'd1003);

    // Ack timeout on the arm write: strobe high exactly 16 cycles.
    run_meas(1, 1'b0, 1'b1, 0, 32'd1, 32'd2);
    check("tmo_ntx", log_q.size(), 2);
    check("tmo_arm_len", log_q[1].len, 16);
    check("tmo_arm_term", log_q[1].term, 3'b000);
    check("tmo_arm_dat", log_q[1].dat, 32'h80);
    check("tmo_error", res_err, 2);

    // Two retries on the reset write, then ack.
    run_meas(1, 1'b0, 1'b0, 2, 32'd21, 32'd22);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rty_tx%0d_req", i), {log_q[i].we, log_q[i].addr, log_q[i].dat}, {1'b1, 32'h8, 32'h1});
      check($sformatf("rty_tx%0d_term", i), log_q[i].term, (i < 2) ? 3'b010 : 3'b001);
      if (i > 0) check($sformatf("rty_tx%0d_gap", i), log_q[i].start - log_q[i-1].fall, 1);
    end
    check("rty_error", res_err, 0);
    check("rty_coarse", res_c, 32'd21);

    // Four retries in a row exhaust the budget.
    run_meas(1, 1'b0, 1'b0, 4, 32'd31, 32'd32);
    check("rty4_ntx", log_q.size(), 4);
    check("rty4_last_term", log_q[3].term, 3'b010);
    check("rty4_error", res_err, 1);
    check("rty4_coarse_kept", res_c, 32'd21);

    // Reset while a poll read has its strobe up.
    cfg_done_on = 0; cfg_err_c = 1'b0; cfg_noack = 1'b0; rty_left = 0; poll_reads = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (stb_o && !we_o && addr_o == 32'h8) found = 1'b1;
    end
    check("midrst_poll_seen", found, 1);
    done_cnt = 0;
    #2 ext_rst_i = 1'b0;
    #1;
    check_zero("midrst");
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    ext_rst_i = 1'b1;
    repeat (2) @(negedge clk);

    // Restart after reset; extra start pulses while busy are ignored.
    cfg_done_on = 1; cfg_c = 32'h1234; cfg_f = 32'h5678; poll_reads = 0;
    log_q.delete();
    done_cnt = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      start_i = (i == 3 || i == 8 || i == 12);
      if (done_o) begin
        got_done = 1'b1;
        res_err = error_o; res_c = coarse_o; res_f = fine_o;
      end
    end
    start_i = 1'b0;
    check("restart_done_seen", got_done, 1);
    repeat (20) @(negedge clk);
    check("restart_single_done", done_cnt, 1);
    check("restart_ntx", log_q.size(), 6);
    check("restart_first_tx", {log_q[0].we, log_q[0].addr, log_q[0].dat}, {1'b1, 32'h8, 32'h1});
    check("restart_busy_idle", busy_o, 0);
    check("restart_error", res_err, 0);
    check("restart_coarse", res_c, 32'h1234);
    check("restart_fine", res_f, 32'h5678);

    check("sel_rule", sel_viol, 0);
    check("req_stable_under_stb", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/freq_counter_wb_master.md
Name: freq_counter_wb_master

Overview:
Wishbone classic initiator that runs one complete frequency measurement on the frequency counter peripheral. On a start request it:
- resets the counter, then arms it;
- polls the done flag;
- reads the coarse and fine counts, then clears the control register.

It sits between the control unit and the counter's Wishbone slave port. Results are presented on parallel outputs with a one-cycle done pulse.

Parameters:
CTRL_ADDR, 32'h8, counter control register address (bit7 start, bit6 done, bit0 reset)
COARSE_ADDR, 32'h9, coarse count register address
FINE_ADDR, 32'hA, fine count register address
ACK_TIMEOUT, 16, max cycles stb_o stays high without ack_i/err_i/rty_i
RETRY_MAX, 3, max rty_i retries per transaction
POLL_GAP, 8, idle cycles between done-flag polls
POLL_LIMIT, 1024, max polls before poll-timeout error (16-bit poll counter)

Ports:
clk_i  in  1  system clock; all logic on rising edge
ext_rst_i  in  1  asynchronous active-low reset
start_i  in  1  measurement request; sampled only in IDLE
addr_o  out  32  Wishbone address
dat_o  out  32  Wishbone write data
dat_i  in  32  Wishbone read data
we_o  out  1  write enable
sel_o  out  4  byte select
cyc_o  out  1  bus cycle
stb_o  out  1  strobe
ack_i  in  1  slave acknowledge
err_i  in  1  slave error
rty_i  in  1  slave retry
busy_o  out  1  high from the first cycle after accepted start_i until done_o
done_o  out  1  one-cycle pulse: measurement sequence ended (success or error)
coarse_o  out  32  last captured coarse count
fine_o  out  32  last captured fine count
error_o  out  2  0 ok, 1 bus err_i / retries exhausted, 2 ack timeout, 3 poll timeout

Behaviour:
- Reset (ext_rst_i=0, asynchronous): state IDLE; all outputs 0, including addr_o, dat_o, sel_o, coarse_o, fine_o and error_o. All internal counters 0.
- Reset mid-transaction: cyc_o/stb_o drop immediately; no done_o is generated.
- All outputs are registered.
- Bus handshake:
  - cyc_o and stb_o rise together; sel_o=4'hF while cyc_o=1, 0 otherwise.
  - addr_o, we_o and dat_o are stable while stb_o=1.
  - The transaction terminates on the first rising edge where ack_i, err_i or rty_i is 1; cyc_o/stb_o deassert on that edge.
  - At least one idle cycle (cyc_o=0) between transactions, because the slave's registered ack must fall first.
  - Priority when several terminators are high at once: err_i > rty_i > ack_i.
  - Reads capture dat_i on the ack edge.
  - Writes drive data zero-extended to 32 bits; reads drive dat_o=0.
- State machine:
  - IDLE: start_i=1 -> WR_RST. start_i is ignored in every other state.
  - WR_RST: write 32'h01 to CTRL_ADDR -> WR_ARM.
  - WR_ARM: write 32'h80 to CTRL_ADDR -> RD_POLL.
  - RD_POLL: read CTRL_ADDR.
    - dat_i[6]=1 -> RD_COARSE.
    - dat_i[6]=0 -> POLL_WAIT and increment the poll counter; when the poll counter reaches POLL_LIMIT, error 3 -> FINISH.
  - POLL_WAIT: idle POLL_GAP cycles -> RD_POLL.
  - RD_COARSE: read COARSE_ADDR into the coarse holding register -> RD_FINE.
  - RD_FINE: read FINE_ADDR into the fine holding register -> WR_CLR.
  - WR_CLR: write 32'h00 to CTRL_ADDR -> FINISH.
  - FINISH:
    - On success, update coarse_o/fine_o from the holding registers.
    - On error, coarse_o/fine_o keep their previous values.
    - error_o updates, done_o=1 for one cycle, busy_o=0 -> IDLE.
- Error rules:
  - err_i: error 1, abort the sequence and go to FINISH without WR_CLR.
  - rty_i: reissue the same transaction after one idle cycle. The (RETRY_MAX+1)th rty_i on one transaction gives error 1.
  - Ack timeout: stb_o high for ACK_TIMEOUT cycles with no terminator gives error 2. stb_o drops on that edge.
  - The ack timeout and retry counters reset at each new transaction.
- error_o clears to 0 on the cycle start_i is accepted.
- coarse_o and fine_o hold their values until the next successful FINISH.
- Latency: with a slave acking on the second stb_o edge, each transaction is 3 cycles (2 stb_o + 1 idle).

Test Plan:
- Nominal: slave model sets done on the 3rd poll, coarse=32'd1000, fine=32'd1003. Required: bus sequence W8=01, W8=80, R8 x3 separated by 8 idle cycles, R9, RA, W8=00. Then done_o pulse, coarse_o=1000, fine_o=1003, error_o=0, busy_o low after the pulse.
- err_i on the RD_COARSE read. Required: no RA read and no W8=00; done_o pulse, error_o=1, coarse_o/fine_o unchanged from the previous run.
- Slave never acks WR_ARM. Required: stb_o high exactly 16 cycles then low; error_o=2, done_o pulse.
- rty_i twice on WR_RST, then ack. Required: 3 identical W8=01 attempts, each separated by 1 idle cycle; sequence completes with error_o=0. Second case: 4 rty_i in a row gives error_o=1.
- Done flag never set, POLL_LIMIT overridden to 4. Required: exactly 4 R8 reads, then error_o=3, done_o pulse.
- ext_rst_i pulled low during RD_POLL with stb_o=1. Required: cyc_o/stb_o=0 asynchronously, all outputs 0, no done_o. After release, start_i=1 restarts the sequence with W8=01. start_i pulses while busy_o=1 have no effect.
